// File: rtl/mem_wb_stage_hs.sv
// mem_wb_stage_hs: memory stage with a req/ack data-memory handshake, lane steering and the MEM/WB register.
// Optional performance counters (perf_acc_o, perf_stall_o) are built when MEMSTAGE_PERF_EN is defined.
module mem_wb_stage_hs #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 19,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_m,
    input  logic                reg_write_m,
    input  logic                result_src_m,
    input  logic                mem_read_m,
    input  logic                mem_write_m,
    input  logic [1:0]          size_m,
    input  logic                sign_m,
    input  logic [REG_W-1:0]    rd_m,
    input  logic [DATA_W-1:0]   alu_result_m,
    input  logic [DATA_W-1:0]   write_data_m,
    input  logic                flush_i,
    output logic                stall_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    input  logic                mem_ack_i,
    output logic                valid_w,
    output logic                reg_write_w,
    output logic                result_src_w,
    output logic [REG_W-1:0]    rd_w,
    output logic [DATA_W-1:0]   alu_result_w,
    output logic [DATA_W-1:0]   read_data_w,
`ifdef MEMSTAGE_PERF_EN
    output logic [31:0]         perf_acc_o,
    output logic [31:0]         perf_stall_o,
`endif
    output logic                err_w
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_n_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_n_s;
    logic              acc_s;
    logic              mis_s;
    logic              req_s;
    logic              timeout_hit_s;
    logic              stall_s;
    logic              done_s;
    logic              err_s;
    logic [OFF_W-1:0]  off_s;
    logic [DATA_W-1:0] shifted_s;
    logic [DATA_W-1:0] load_data_s;

    // Keep the low nbits of val and fill the rest with zeros or the copied sign bit.
    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] val,
                                                 input int nbits, input logic sgn);
        logic [DATA_W-1:0] res;
        res = {DATA_W{1'b0}};
        for (int i = 0; i < DATA_W; i++) begin
            if (i < nbits) begin
                res[i] = val[i];
            end else begin
                res[i] = sgn & val[nbits-1];
            end
        end
        return res;
    endfunction

    generate
        if (ADDR_W < DATA_W) begin : g_addr_unused
            logic unused_addr_s;
            assign unused_addr_s = ^alu_result_m[DATA_W-1:ADDR_W];
        end
    endgenerate

    assign acc_s = valid_m & (mem_read_m | mem_write_m);
    assign off_s = alu_result_m[OFF_W-1:0];

    // Misalignment: halves need an even lane, words (and the reserved size) need lane 0.
    always_comb begin
        mis_s = 1'b0;
        case (size_m)
            2'b00:   mis_s = 1'b0;
            2'b01:   mis_s = off_s[0];
            default: mis_s = (off_s != {OFF_W{1'b0}});
        endcase
    end

    // The request is dropped immediately on flush or reset; a late ack is then ignored.
    assign req_s         = acc_s & ~mis_s & ~flush_i & ~reset;
    assign timeout_hit_s = (state_r == ST_BUSY) & req_s & ~mem_ack_i &
                           (cnt_r == CNT_W'(TIMEOUT - 1));
    assign stall_s       = req_s & ~mem_ack_i & ~timeout_hit_s;
    assign done_s        = ~flush_i & ~stall_s;
    assign err_s         = (acc_s & mis_s) | timeout_hit_s;

    assign stall_o    = stall_s;
    assign mem_req_o  = req_s;
    assign mem_we_o   = mem_write_m;
    assign mem_addr_o = {alu_result_m[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // Store lane steering: replicate the right-aligned data and enable only the addressed bytes.
    always_comb begin
        mem_wdata_o = {DATA_W{1'b0}};
        mem_be_o    = {NB{1'b0}};
        for (int i = 0; i < NB; i++) begin
            case (size_m)
                2'b00:   mem_wdata_o[i*8 +: 8] = write_data_m[7:0];
                2'b01:   mem_wdata_o[i*8 +: 8] = write_data_m[(i%2)*8 +: 8];
                default: mem_wdata_o[i*8 +: 8] = write_data_m[i*8 +: 8];
            endcase
        end
        case (size_m)
            2'b00:   mem_be_o = NB'(1'b1) << off_s;
            2'b01:   mem_be_o = NB'(2'b11) << off_s;
            default: mem_be_o = {NB{1'b1}};
        endcase
    end

    assign shifted_s = mem_rdata_i >> {off_s, 3'b000};

    // Load alignment: pick the addressed bytes out of the word and extend them.
    always_comb begin
        load_data_s = {DATA_W{1'b0}};
        case (size_m)
            2'b00:   load_data_s = extend(shifted_s, 8, sign_m);
            2'b01:   load_data_s = extend(shifted_s, 16, sign_m);
            default: load_data_s = shifted_s;
        endcase
    end

    // Next state: flush and completion return to IDLE; a held request waits in BUSY counting cycles.
    always_comb begin
        state_n_s = state_r;
        cnt_n_s   = cnt_r;
        if (flush_i) begin
            state_n_s = ST_IDLE;
            cnt_n_s   = {CNT_W{1'b0}};
        end else if (stall_s) begin
            state_n_s = ST_BUSY;
            if (state_r == ST_BUSY) begin
                cnt_n_s = cnt_r + CNT_W'(1);
            end else begin
                cnt_n_s = {CNT_W{1'b0}};
            end
        end else begin
            state_n_s = ST_IDLE;
            cnt_n_s   = {CNT_W{1'b0}};
        end
    end

    // FSM state and wait-cycle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_n_s;
            cnt_r   <= cnt_n_s;
        end
    end

    // MEM/WB register: completion loads the instruction, stall or flush loads a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_w      <= 1'b0;
            reg_write_w  <= 1'b0;
            result_src_w <= 1'b0;
            rd_w         <= {REG_W{1'b0}};
            alu_result_w <= {DATA_W{1'b0}};
            read_data_w  <= {DATA_W{1'b0}};
            err_w        <= 1'b0;
        end else if (done_s) begin
            valid_w      <= valid_m;
            reg_write_w  <= reg_write_m & ~err_s;
            result_src_w <= result_src_m;
            rd_w         <= rd_m;
            alu_result_w <= alu_result_m;
            read_data_w  <= (acc_s & mem_read_m & ~err_s) ? load_data_s : {DATA_W{1'b0}};
            err_w        <= err_s;
        end else begin
            valid_w      <= 1'b0;
            reg_write_w  <= 1'b0;
            result_src_w <= 1'b0;
            rd_w         <= {REG_W{1'b0}};
            alu_result_w <= {DATA_W{1'b0}};
            read_data_w  <= {DATA_W{1'b0}};
            err_w        <= 1'b0;
        end
    end

`ifdef MEMSTAGE_PERF_EN
    // Counts handshake completions (ack or timeout) and stall cycles; both wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_acc_o   <= 32'd0;
            perf_stall_o <= 32'd0;
        end else begin
            if (done_s & req_s) begin
                perf_acc_o <= perf_acc_o + 32'd1;
            end else begin
                perf_acc_o <= perf_acc_o;
            end
            if (stall_s) begin
                perf_stall_o <= perf_stall_o + 32'd1;
            end else begin
                perf_stall_o <= perf_stall_o;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_wb_stage_hs.sv
// Self-checking bench for mem_wb_stage_hs: transaction-level model, per-cycle compare process,
// directed scenarios with literal expectations, then randomized instructions.
`timescale 1ns/1ps
module tb_mem_wb_stage_hs;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 19;
    localparam int REG_W   = 5;
    localparam int TIMEOUT = 16;
    localparam int NB      = 4;

    typedef struct packed {
        logic        valid;
        logic        rw;
        logic        rsrc;
        logic        err;
        logic        full;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rdat;
    } wexp_t;

    localparam wexp_t RST_W = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 32'd0};
    localparam wexp_t BUB_W = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic valid_m = 1'b0, reg_write_m = 1'b0, result_src_m = 1'b0;
    logic mem_read_m = 1'b0, mem_write_m = 1'b0, sign_m = 1'b0;
    logic [1:0] size_m = 2'b00;
    logic [REG_W-1:0] rd_m = '0;
    logic [DATA_W-1:0] alu_result_m = '0, write_data_m = '0, mem_rdata_i = '0;
    logic flush_i = 1'b0, mem_ack_i = 1'b0;
    logic stall_o, mem_req_o, mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [NB-1:0] mem_be_o;
    logic valid_w, reg_write_w, result_src_w, err_w;
    logic [REG_W-1:0] rd_w;
    logic [DATA_W-1:0] alu_result_w, read_data_w;

    mem_wb_stage_hs #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .valid_m(valid_m), .reg_write_m(reg_write_m),
        .result_src_m(result_src_m), .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
        .size_m(size_m), .sign_m(sign_m), .rd_m(rd_m), .alu_result_m(alu_result_m),
        .write_data_m(write_data_m), .flush_i(flush_i), .stall_o(stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i),
        .mem_ack_i(mem_ack_i), .valid_w(valid_w), .reg_write_w(reg_write_w),
        .result_src_w(result_src_w), .rd_w(rd_w), .alu_result_w(alu_result_w),
        .read_data_w(read_data_w), .err_w(err_w)
    );

    always #5 clk = ~clk;

    // Expectations written by the driver
    logic chk_on = 1'b0, cnt_clr = 1'b0, ack_force = 1'b0;
    logic e_req = 1'b0, e_stall = 1'b0, e_we = 1'b0;
    logic [ADDR_W-1:0] e_addr = '0;
    logic [NB-1:0] e_be = '0;
    logic [31:0] e_wdata = '0;
    wexp_t w_next = RST_W;
    wexp_t w_cur = RST_W;
    logic lit_on = 1'b0;
    logic [9:0] lit_mask = '0;
    logic lit_valid = 1'b0, lit_rw = 1'b0, lit_err = 1'b0;
    logic [4:0] lit_rd = '0;
    logic [31:0] lit_alu = '0, lit_rdat = '0, lit_wdata = '0;
    int lit_stalls = 0, lit_reqs = 0;
    logic [3:0] lit_be = '0;

    // Written only by the compare process
    int n_tests = 0, n_fail = 0, stall_seen = 0, req_seen = 0;
    logic [3:0] first_be = '0;
    logic [31:0] first_wdata = '0;

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : NB;
    endfunction

    function automatic logic [3:0] model_be(input int off, input int nb);
        return 4'(((1 << nb) - 1) << off);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] wd, input int nb);
        longint low, r;
        low = longint'(wd) & ((longint'(1) << (8 * nb)) - 1);
        r = 0;
        for (int j = 0; j < NB / nb; j++) r = r | (low << (8 * nb * j));
        return 32'(r);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rd, input int off,
                                               input int nb, input logic sg);
        longint v, mask;
        mask = (longint'(1) << (8 * nb)) - 1;
        v = (longint'(rd) >> (8 * off)) & mask;
        if (sg && nb < NB && ((v >> (8 * nb - 1)) & 1) == 1) v = v | ~mask;
        return 32'(v);
    endfunction

    // The W expectation advances with the DUT's clock and is cleared by reset like the real register.
    always @(posedge clk or posedge reset) begin
        if (reset) w_cur <= RST_W;
        else       w_cur <= w_next;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Compare process: every negedge, outputs vs model, plus pending literal checks.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("mem_req_o", mem_req_o, e_req);
            chk("stall_o", stall_o, e_stall);
            if (e_req) begin
                chk("mem_we_o", mem_we_o, e_we);
                chk("mem_addr_o", mem_addr_o, e_addr);
                chk("mem_be_o", mem_be_o, e_be);
                chk("mem_wdata_o", mem_wdata_o, e_wdata);
            end
            chk("valid_w", valid_w, w_cur.valid);
            chk("reg_write_w", reg_write_w, w_cur.rw);
            chk("err_w", err_w, w_cur.err);
            if (w_cur.full) begin
                chk("result_src_w", result_src_w, w_cur.rsrc);
                chk("rd_w", rd_w, w_cur.rd);
                chk("alu_result_w", alu_result_w, w_cur.alu);
                chk("read_data_w", read_data_w, w_cur.rdat);
            end
            if (lit_on) begin
                if (lit_mask[0]) chk("lit_valid_w", valid_w, lit_valid);
                if (lit_mask[1]) chk("lit_reg_write_w", reg_write_w, lit_rw);
                if (lit_mask[2]) chk("lit_err_w", err_w, lit_err);
                if (lit_mask[3]) chk("lit_rd_w", rd_w, lit_rd);
                if (lit_mask[4]) chk("lit_alu_result_w", alu_result_w, lit_alu);
                if (lit_mask[5]) chk("lit_read_data_w", read_data_w, lit_rdat);
                if (lit_mask[6]) chk("lit_stall_cycles", stall_seen, lit_stalls);
                if (lit_mask[7]) chk("lit_req_cycles", req_seen, lit_reqs);
                if (lit_mask[8]) chk("lit_mem_be_o", first_be, lit_be);
                if (lit_mask[9]) chk("lit_mem_wdata_o", first_wdata, lit_wdata);
            end
            if (cnt_clr) begin
                stall_seen = int'(stall_o);
                req_seen = int'(mem_req_o);
                first_be = mem_be_o;
                first_wdata = mem_wdata_o;
            end else begin
                stall_seen += int'(stall_o);
                req_seen += int'(mem_req_o);
            end
        end
    end

    // Present one instruction until it leaves M: d = ack cycle, f = flush cycle, rk = reset cycle (-1 = never).
    task automatic run_instr(input logic v, rw, rs, rdm, wrm, input logic [1:0] sz, input logic sg,
                             input logic [4:0] rd, input logic [31:0] alu, wd,
                             input int d, f, rk, input logic fix, input logic [31:0] rfix);
        int k, off, nb;
        bit acc, mis, req, ack, to, stall, done, err;
        logic [31:0] rdat;
        logic [18:0] a;
        k = 0;
        off = int'(alu[1:0]);
        nb = nbytes(sz);
        acc = v && (rdm || wrm);
        mis = (off % nb) != 0;
        done = 1'b0;
        while (!done) begin
            if (k == rk) reset = 1'b1;
            req = acc && !mis && (k != f) && !reset;
            ack = req ? (k == d) : (ack_force ? 1'b1 : 1'($urandom_range(0, 1)));
            rdat = fix ? rfix : $urandom;
            to = req && !ack && (k == TIMEOUT);
            stall = req && !ack && !to;
            valid_m = v; reg_write_m = rw; result_src_m = rs; mem_read_m = rdm;
            mem_write_m = wrm; size_m = sz; sign_m = sg; rd_m = rd; alu_result_m = alu;
            write_data_m = wd; mem_rdata_i = rdat; mem_ack_i = ack; flush_i = (k == f);
            e_req = req; e_stall = stall; e_we = wrm;
            a = alu[18:0]; a[1:0] = 2'b00; e_addr = a;
            e_be = model_be(off, nb);
            e_wdata = model_wdata(wd, nb);
            if (reset) begin
                w_next = RST_W;
            end else if (k == f || stall) begin
                w_next = BUB_W;
            end else begin
                err = (acc && mis) || to;
                w_next.valid = v; w_next.rw = rw && !err; w_next.rsrc = rs; w_next.err = err;
                w_next.full = 1'b1; w_next.rd = rd; w_next.alu = alu;
                w_next.rdat = (acc && rdm && !err) ? model_load(rdat, off, nb, sg) : 32'h0;
            end
            done = reset || (k == f) || !stall;
            if (k == 0) cnt_clr = 1'b1;
            @(posedge clk);
            #2;
            cnt_clr = 1'b0;
            lit_on = 1'b0;
            k++;
        end
    endtask

    task automatic set_lit(input logic [9:0] m, input logic lv, lrw, lerr, input logic [4:0] lrd,
                           input logic [31:0] lalu, lrdat, input int ls, lq,
                           input logic [3:0] lbe, input logic [31:0] lwd);
        lit_mask = m; lit_valid = lv; lit_rw = lrw; lit_err = lerr; lit_rd = lrd;
        lit_alu = lalu; lit_rdat = lrdat; lit_stalls = ls; lit_reqs = lq;
        lit_be = lbe; lit_wdata = lwd; lit_on = 1'b1;
    endtask

    initial begin
        int d, f, r, op;
        logic v, rw, rs, rdm, wrm, sg;
        logic [1:0] sz;
        logic [31:0] alu;
        @(posedge clk);
        #2;
        chk_on = 1'b1;
        // Reset held with a pending access: no request, no stall, W all zero
        run_instr(1, 1, 1, 1, 0, 2'd2, 0, 5'd3, 32'h40, 32'h0, 0, -1, 0, 0, 32'h0);
        run_instr(1, 0, 0, 0, 1, 2'd0, 0, 5'd4, 32'h41, 32'h5A, 2, -1, 0, 0, 32'h0);
        reset = 1'b0;
        // ALU pass-through
        run_instr(1, 1, 0, 0, 0, 2'd2, 0, 5'd7, 32'h1234, 32'h0, 0, -1, -1, 0, 32'h0);
        set_lit(10'b00_0101_1001, 1, 0, 0, 5'd7, 32'h1234, 0, 0, 0, 4'h0, 0);
        // Signed then unsigned byte load at lane 3
        run_instr(1, 1, 1, 1, 0, 2'd0, 1, 5'd3, 32'h3, 32'h0, 0, -1, -1, 1, 32'h80FF_0000);
        set_lit(10'b01_0010_0011, 1, 1, 0, 5'd0, 0, 32'hFFFF_FF80, 0, 0, 4'b1000, 0);
        run_instr(1, 1, 1, 1, 0, 2'd0, 0, 5'd3, 32'h3, 32'h0, 0, -1, -1, 1, 32'h80FF_0000);
        set_lit(10'b00_0010_0001, 1, 0, 0, 5'd0, 0, 32'h0000_0080, 0, 0, 4'h0, 0);
        // Half store with three wait states
        run_instr(1, 0, 0, 0, 1, 2'd1, 0, 5'd0, 32'h2, 32'h0000_BEEF, 3, -1, -1, 0, 32'h0);
        set_lit(10'b11_0110_0001, 1, 0, 0, 5'd0, 0, 32'h0, 3, 0, 4'b1100, 32'hBEEF_BEEF);
        // Misaligned word load
        run_instr(1, 1, 1, 1, 0, 2'd2, 0, 5'd5, 32'h1, 32'h0, 0, -1, -1, 0, 32'h0);
        set_lit(10'b00_1000_0111, 1, 0, 1, 5'd0, 0, 0, 0, 0, 4'h0, 0);
        // Timeout
        run_instr(1, 1, 1, 1, 0, 2'd2, 0, 5'd6, 32'h100, 32'h0, 1000, -1, -1, 0, 32'h0);
        set_lit(10'b00_0110_0111, 1, 0, 1, 5'd0, 0, 32'h0, 16, 0, 4'h0, 0);
        // Flush on BUSY cycle 2, then an ack while no request is outstanding
        run_instr(1, 1, 1, 1, 0, 2'd2, 0, 5'd8, 32'h8, 32'h0, 1000, 2, -1, 0, 32'h0);
        set_lit(10'b00_0000_0111, 0, 0, 0, 5'd0, 0, 0, 0, 0, 4'h0, 0);
        ack_force = 1'b1;
        run_instr(1, 1, 0, 0, 0, 2'd2, 0, 5'd9, 32'h55, 32'h0, 0, -1, -1, 0, 32'h0);
        ack_force = 1'b0;
        set_lit(10'b00_1000_1101, 1, 0, 0, 5'd9, 0, 0, 0, 0, 4'h0, 0);
        // Reset mid-access, then a zero-wait load from a clean IDLE
        run_instr(1, 1, 1, 1, 0, 2'd2, 0, 5'd10, 32'h10, 32'h0, 1000, -1, 2, 0, 32'h0);
        reset = 1'b0;
        run_instr(1, 1, 1, 1, 0, 2'd2, 0, 5'd11, 32'h20, 32'h0, 0, -1, -1, 1, 32'hCAFE_F00D);
        set_lit(10'b00_0110_0001, 1, 0, 0, 5'd0, 0, 32'hCAFE_F00D, 0, 0, 4'h0, 0);
        // Randomized instruction stream
        for (int n = 0; n < 400; n++) begin
            v = ($urandom_range(0, 9) != 0);
            op = $urandom_range(0, 2);
            rdm = (op == 1);
            wrm = (op == 2);
            rw = v && ((op == 1) || (op == 0 && $urandom_range(0, 1) == 1));
            rs = rdm ? 1'b1 : 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            alu = $urandom;
            if ($urandom_range(0, 1) == 1) alu[1:0] = 2'b00;
            r = $urandom_range(0, 9);
            d = (r < 6) ? $urandom_range(0, 3) : (r < 8) ? $urandom_range(4, 17) : 1000;
            f = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 4) : -1;
            run_instr(v, rw, rs, rdm, wrm, sz, sg, 5'($urandom), alu, $urandom, d, f, -1, 0, 32'h0);
        end
        run_instr(0, 0, 0, 0, 0, 2'd0, 0, 5'd0, 32'h0, 32'h0, 0, -1, -1, 0, 32'h0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
